// File: rtl/game_fsm_param.sv
// game_fsm_param: two-player warships game controller (placement, start
// handshake, alternating shoot/defend turns, win/lose) with a strobed peer link.
// Latency: a placement, shot or defence takes 3 cycles from strobe to its write
// or message. Strobes that arrive outside an accepting state are dropped.
// Optional macro TURN_TIMEOUT_EN: when defined, a peer answer that takes longer
// than TIMEOUT_CYCLES moves the FSM to a terminal TIMEOUT state.
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   start_btn                 start request (level)
//   place_valid/place_cords   ship placement strobe and linear cell index
//   shot_valid/shot_cords     fire strobe and linear cell index
//   my_mem_* / en_mem_*       own / enemy grid memory (1-cycle read latency)
//   ready2, msg2, hit2, cords_in   peer link inputs
//   ready1, msg1, hit1, cords_out  peer link outputs
//   my_ctr, en_ctr            live ship cells, own / enemy
//   place_reject, shot_reject 1-cycle reject strobes
//   win, lose, timeout        sticky end-of-game flags
module game_fsm_param #(
   parameter int GRID_W         = 10,
   parameter int GRID_H         = 10,
   parameter int SHIPS_NUMBER   = 10,
   parameter int PLAYER_ID      = 0,
   parameter int TIMEOUT_CYCLES = 65000000,
   localparam int CELLS = GRID_W * GRID_H,
   localparam int AW    = $clog2(CELLS),
   localparam int CW    = $clog2(SHIPS_NUMBER + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start_btn,
   input  logic          place_valid,
   input  logic [AW-1:0] place_cords,
   input  logic          shot_valid,
   input  logic [AW-1:0] shot_cords,
   output logic [AW-1:0] my_mem_addr,
   input  logic [1:0]    my_mem_data_in,
   output logic [1:0]    my_mem_data_out,
   output logic          my_mem_we,
   output logic [AW-1:0] en_mem_addr,
   input  logic [1:0]    en_mem_data_in,
   output logic [1:0]    en_mem_data_out,
   output logic          en_mem_we,
   input  logic          ready2,
   input  logic          msg2,
   input  logic          hit2,
   input  logic [AW-1:0] cords_in,
   output logic          ready1,
   output logic          msg1,
   output logic          hit1,
   output logic [AW-1:0] cords_out,
   output logic [CW-1:0] my_ctr,
   output logic [CW-1:0] en_ctr,
   output logic          place_reject,
   output logic          shot_reject,
   output logic          win,
   output logic          lose,
   output logic          timeout
);

   localparam logic [1:0]    C_EMPTY  = 2'b00;
   localparam logic [1:0]    C_MYSHIP = 2'b01;
   localparam logic [1:0]    C_MISS   = 2'b10;
   localparam logic [1:0]    C_HIT    = 2'b11;
   localparam logic [AW:0]   CELLS_L  = (AW+1)'(CELLS);
   localparam logic [CW-1:0] SHIPS_L  = CW'(SHIPS_NUMBER);
   localparam logic [CW-1:0] ONE_L    = CW'(1);

   typedef enum logic [3:0] {
      S_IDLE, S_PLACE_RD, S_PLACE_CHK, S_JOIN,
      S_WAIT_SHOT, S_SHOT_RD, S_SHOT_CHK, S_WAIT_ANSWER,
      S_WAIT_ENEMY, S_DEF_RD, S_DEF_CHK,
      S_WIN, S_LOSE, S_TIMEOUT
   } state_t;

   state_t        state;
   logic [AW-1:0] cords_q;    // cell under test for the current request
   logic          in_range;
   logic          tmr_exp;    // peer answer overdue

   assign in_range = ({1'b0, cords_q} < CELLS_L);

`ifdef TURN_TIMEOUT_EN
   localparam int           TW    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_L = TW'(TIMEOUT_CYCLES);
   logic [TW-1:0] tmr;

   // Held at the full budget outside the two peer waits, so it is freshly
   // loaded on every entry; msg2 also reloads it for the WAIT_ANSWER ->
   // WAIT_ENEMY hop.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tmr <= TMO_L;
      end else if (!(state == S_WAIT_ANSWER || state == S_WAIT_ENEMY) || msg2) begin
         tmr <= TMO_L;
      end else if (tmr != '0) begin
         tmr <= tmr - 1'b1;
      end
   end

   assign tmr_exp = (tmr <= TW'(1));
`else
   assign tmr_exp = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state           <= S_IDLE;
         cords_q         <= '0;
         my_mem_addr     <= '0;
         my_mem_data_out <= C_EMPTY;
         my_mem_we       <= 1'b0;
         en_mem_addr     <= '0;
         en_mem_data_out <= C_EMPTY;
         en_mem_we       <= 1'b0;
         ready1          <= 1'b0;
         msg1            <= 1'b0;
         hit1            <= 1'b0;
         cords_out       <= '0;
         my_ctr          <= '0;
         en_ctr          <= SHIPS_L;
         place_reject    <= 1'b0;
         shot_reject     <= 1'b0;
         win             <= 1'b0;
         lose            <= 1'b0;
         timeout         <= 1'b0;
      end else begin
         // single-cycle strobes
         my_mem_we    <= 1'b0;
         en_mem_we    <= 1'b0;
         msg1         <= 1'b0;
         place_reject <= 1'b0;
         shot_reject  <= 1'b0;

         case (state)
            S_IDLE: begin
               // placement has priority; start is only eligible once the
               // fleet is complete, when placement is no longer accepted
               if (place_valid && my_ctr < SHIPS_L) begin
                  cords_q     <= place_cords;
                  my_mem_addr <= place_cords;
                  state       <= S_PLACE_RD;
               end else if (start_btn && my_ctr == SHIPS_L) begin
                  ready1 <= 1'b1;
                  state  <= S_JOIN;
               end
            end

            S_PLACE_RD: begin
               if (!in_range) begin
                  place_reject <= 1'b1;
                  state        <= S_IDLE;
               end else begin
                  state <= S_PLACE_CHK;
               end
            end

            S_PLACE_CHK: begin
               if (my_mem_data_in == C_EMPTY && my_ctr < SHIPS_L) begin
                  my_mem_we       <= 1'b1;
                  my_mem_data_out <= C_MYSHIP;
                  my_ctr          <= my_ctr + 1'b1;
               end else begin
                  place_reject <= 1'b1;
               end
               state <= S_IDLE;
            end

            S_JOIN: begin
               if (ready2) begin
                  state <= (PLAYER_ID == 0) ? S_WAIT_SHOT : S_WAIT_ENEMY;
               end
            end

            S_WAIT_SHOT: begin
               if (shot_valid) begin
                  cords_q     <= shot_cords;
                  en_mem_addr <= shot_cords;
                  state       <= S_SHOT_RD;
               end
            end

            S_SHOT_RD: begin
               if (!in_range) begin
                  shot_reject <= 1'b1;
                  state       <= S_WAIT_SHOT;
               end else begin
                  state <= S_SHOT_CHK;
               end
            end

            S_SHOT_CHK: begin
               if (en_mem_data_in != C_EMPTY) begin
                  shot_reject <= 1'b1;
                  state       <= S_WAIT_SHOT;
               end else begin
                  msg1      <= 1'b1;
                  hit1      <= 1'b0;
                  cords_out <= cords_q;
                  state     <= S_WAIT_ANSWER;
               end
            end

            S_WAIT_ANSWER: begin
               if (msg2) begin
                  // en_mem_addr still holds the shot cell
                  en_mem_we       <= 1'b1;
                  en_mem_data_out <= hit2 ? C_HIT : C_MISS;
                  if (hit2 && en_ctr != '0) begin
                     en_ctr <= en_ctr - 1'b1;
                  end
                  if (hit2 && en_ctr <= ONE_L) begin
                     win   <= 1'b1;
                     state <= S_WIN;
                  end else begin
                     state <= S_WAIT_ENEMY;
                  end
               end else if (tmr_exp) begin
                  timeout <= 1'b1;
                  ready1  <= 1'b0;
                  state   <= S_TIMEOUT;
               end
            end

            S_WAIT_ENEMY: begin
               if (msg2) begin
                  cords_q     <= cords_in;
                  my_mem_addr <= cords_in;
                  state       <= S_DEF_RD;
               end else if (tmr_exp) begin
                  timeout <= 1'b1;
                  ready1  <= 1'b0;
                  state   <= S_TIMEOUT;
               end
            end

            S_DEF_RD: begin
               state <= S_DEF_CHK;
            end

            S_DEF_CHK: begin
               // bit 0 of the cell code is set exactly for MYSHIP and HIT,
               // i.e. the cells that answer as a hit
               msg1      <= 1'b1;
               hit1      <= in_range & my_mem_data_in[0];
               cords_out <= cords_q;
               if (in_range && my_mem_data_in == C_MYSHIP) begin
                  my_mem_we       <= 1'b1;
                  my_mem_data_out <= C_HIT;
                  if (my_ctr != '0) begin
                     my_ctr <= my_ctr - 1'b1;
                  end
               end else if (in_range && my_mem_data_in == C_EMPTY) begin
                  my_mem_we       <= 1'b1;
                  my_mem_data_out <= C_MISS;
               end
               if (in_range && my_mem_data_in == C_MYSHIP && my_ctr <= ONE_L) begin
                  lose  <= 1'b1;
                  state <= S_LOSE;
               end else begin
                  state <= S_WAIT_SHOT;
               end
            end

            // terminal states: only reset leaves them
            S_WIN, S_LOSE, S_TIMEOUT: begin
               state <= state;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_game_fsm_param.sv
// tb_game_fsm_param: directed bench for game_fsm_param (10x10 grid, 10 ships,
// PLAYER_ID 0) with behavioural grid memories and pulse monitors; expected
// values are hand-computed constants. Timeout checks build with TURN_TIMEOUT_EN.
module tb_game_fsm_param;

   localparam int AW = 7;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start_btn = 1'b0;
   logic          place_valid = 1'b0;
   logic [AW-1:0] place_cords = '0;
   logic          shot_valid = 1'b0;
   logic [AW-1:0] shot_cords = '0;
   logic [AW-1:0] my_mem_addr, en_mem_addr;
   logic [1:0]    my_rd, en_rd;
   logic [1:0]    my_mem_data_out, en_mem_data_out;
   logic          my_mem_we, en_mem_we;
   logic          ready2 = 1'b0;
   logic          msg2 = 1'b0;
   logic          hit2 = 1'b0;
   logic [AW-1:0] cords_in = '0;
   logic          ready1, msg1, hit1;
   logic [AW-1:0] cords_out;
   logic [CW-1:0] my_ctr, en_ctr;
   logic          place_reject, shot_reject, win, lose, timeout;
   logic          clr = 1'b1;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   game_fsm_param #(
      .GRID_W(10), .GRID_H(10), .SHIPS_NUMBER(10), .PLAYER_ID(0), .TIMEOUT_CYCLES(20)
   ) dut (
      .clk(clk), .rst(rst), .start_btn(start_btn),
      .place_valid(place_valid), .place_cords(place_cords),
      .shot_valid(shot_valid), .shot_cords(shot_cords),
      .my_mem_addr(my_mem_addr), .my_mem_data_in(my_rd),
      .my_mem_data_out(my_mem_data_out), .my_mem_we(my_mem_we),
      .en_mem_addr(en_mem_addr), .en_mem_data_in(en_rd),
      .en_mem_data_out(en_mem_data_out), .en_mem_we(en_mem_we),
      .ready2(ready2), .msg2(msg2), .hit2(hit2), .cords_in(cords_in),
      .ready1(ready1), .msg1(msg1), .hit1(hit1), .cords_out(cords_out),
      .my_ctr(my_ctr), .en_ctr(en_ctr),
      .place_reject(place_reject), .shot_reject(shot_reject),
      .win(win), .lose(lose), .timeout(timeout)
   );

   // grid memories: synchronous read, 1-cycle latency; enemy cell 7 preset MISS
   logic [1:0] my_mem [0:127];
   logic [1:0] en_mem [0:127];
   always @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < 128; i++) begin
            my_mem[i] <= 2'b00;
            en_mem[i] <= (i == 7) ? 2'b10 : 2'b00;
         end
      end else begin
         if (my_mem_we) my_mem[my_mem_addr] <= my_mem_data_out;
         if (en_mem_we) en_mem[en_mem_addr] <= en_mem_data_out;
      end
      my_rd <= my_mem[my_mem_addr];
      en_rd <= en_mem[en_mem_addr];
   end

   // pulse monitors
   int         my_we_cnt = 0, en_we_cnt = 0, msg1_cnt = 0, prej_cnt = 0, srej_cnt = 0;
   logic [1:0] my_wdat = '0, en_wdat = '0;
   logic [AW-1:0] my_waddr = '0, en_waddr = '0, msg_cords = '0;
   logic       msg_hit = 1'b0;
   always @(negedge clk) begin
      if (my_mem_we) begin my_we_cnt++; my_wdat = my_mem_data_out; my_waddr = my_mem_addr; end
      if (en_mem_we) begin en_we_cnt++; en_wdat = en_mem_data_out; en_waddr = en_mem_addr; end
      if (msg1) begin msg1_cnt++; msg_hit = hit1; msg_cords = cords_out; end
      if (place_reject) prej_cnt++;
      if (shot_reject) srej_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic place(input int c);
      place_valid = 1'b1; place_cords = AW'(c);
      tick();
      place_valid = 1'b0;
      tick(4);
   endtask

   task automatic shoot(input int c);
      shot_valid = 1'b1; shot_cords = AW'(c);
      tick();
      shot_valid = 1'b0;
      tick(4);
   endtask

   task automatic answer(input logic h);
      msg2 = 1'b1; hit2 = h;
      tick();
      msg2 = 1'b0; hit2 = 1'b0;
      tick(3);
   endtask

   task automatic attack(input int c);
      msg2 = 1'b1; cords_in = AW'(c);
      tick();
      msg2 = 1'b0;
      tick(5);
   endtask

   task automatic place_fleet();
      for (int i = 0; i < 10; i++) place(i);
   endtask

   task automatic async_reset();
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("async_rst_my_ctr", my_ctr, 0);
      check("async_rst_en_ctr", en_ctr, 10);
      check("async_rst_flags", {win, lose, timeout, ready1, msg1}, 0);
      @(negedge clk);
      clr = 1'b1;
      rst = 1'b1;
      tick();
      clr = 1'b0;
      tick();
   endtask

   int snap;

   initial begin
      // reset state
      tick(3);
      check("rst_my_ctr", my_ctr, 0);
      check("rst_en_ctr", en_ctr, 10);
      check("rst_outputs", {ready1, msg1, hit1, my_mem_we, en_mem_we, place_reject,
                            shot_reject, win, lose, timeout}, 0);
      rst = 1'b1;
      clr = 1'b0;
      tick(2);

      // placement: duplicate and out-of-range rejection
      place(5);
      check("place5_we", my_we_cnt, 1);
      check("place5_data", my_wdat, 2'b01);
      check("place5_addr", my_waddr, 5);
      check("place5_ctr", my_ctr, 1);
      place(5);
      check("dup_reject", prej_cnt, 1);
      check("dup_no_we", my_we_cnt, 1);
      check("dup_ctr", my_ctr, 1);
      place(100);
      check("oob_reject", prej_cnt, 2);
      check("oob_ctr", my_ctr, 1);
      for (int i = 0; i < 10; i++) if (i != 5) place(i);
      check("fleet_we", my_we_cnt, 10);
      check("fleet_ctr", my_ctr, 10);
      place(50);
      check("full_ignored_we", my_we_cnt, 10);
      check("full_ignored_rej", prej_cnt, 2);
      check("full_ignored_ctr", my_ctr, 10);

      // join: shots are dropped while the peer has not joined
      start_btn = 1'b1;
      tick();
      start_btn = 1'b0;
      check("join_ready1", ready1, 1);
      shoot(30);
      check("join_shot_dropped", msg1_cnt, 0);
      check("join_shot_norej", srej_cnt, 0);
      ready2 = 1'b1;
      tick(2);

      // shooting: rejects, then a hit
      shoot(7);
      check("shot_miss_cell_rej", srej_cnt, 1);
      check("shot_miss_cell_nomsg", msg1_cnt, 0);
      shoot(120);
      check("shot_oob_rej", srej_cnt, 2);
      shoot(42);
      check("shot42_msg", msg1_cnt, 1);
      check("shot42_cords", msg_cords, 42);
      check("shot42_hit1", msg_hit, 0);
      answer(1'b1);
      check("ans_hit_we", en_we_cnt, 1);
      check("ans_hit_addr", en_waddr, 42);
      check("ans_hit_data", en_wdat, 2'b11);
      check("ans_hit_ctr", en_ctr, 9);

      // defending
      attack(3);
      check("def3_we", my_we_cnt, 11);
      check("def3_data", my_wdat, 2'b11);
      check("def3_ctr", my_ctr, 9);
      check("def3_msg", msg1_cnt, 2);
      check("def3_hit1", msg_hit, 1);
      check("def3_cords", msg_cords, 3);
      shoot(43);
      answer(1'b0);
      check("ans_miss_data", en_wdat, 2'b10);
      check("ans_miss_ctr", en_ctr, 9);
      attack(3);
      check("def3_again_hit1", msg_hit, 1);
      check("def3_again_nowe", my_we_cnt, 11);
      check("def3_again_ctr", my_ctr, 9);
      check("def3_again_msg", msg1_cnt, 4);
      shoot(44);
      answer(1'b0);
      attack(50);
      check("def_empty_hit1", msg_hit, 0);
      check("def_empty_data", my_wdat, 2'b10);
      check("def_empty_we", my_we_cnt, 12);
      shoot(43);
      check("reshot_rej", srej_cnt, 3);
      check("reshot_nomsg", msg1_cnt, 6);

      // nine more hits win the game
      for (int i = 0; i < 9; i++) begin
         shoot(60 + i);
         answer(1'b1);
         if (i < 8) attack(70 + i);
      end
      check("win_flag", win, 1);
      check("win_en_ctr", en_ctr, 0);
      check("win_no_lose", lose, 0);
      check("win_msgs", msg1_cnt, 23);
      snap = msg1_cnt;
      shoot(80);
      attack(4);
      place(90);
      check("win_terminal_msg", msg1_cnt, snap);
      check("win_terminal_we", my_we_cnt, 20);
      check("win_held", win, 1);

      // second game: ten own hits lose
      async_reset();
      place_fleet();
      start_btn = 1'b1;
      tick();
      start_btn = 1'b0;
      tick(2);
      for (int i = 0; i < 10; i++) begin
         shoot(20 + i);
         answer(1'b0);
         attack(i);
      end
      check("lose_flag", lose, 1);
      check("lose_my_ctr", my_ctr, 0);
      check("lose_no_win", win, 0);
      check("lose_en_ctr", en_ctr, 10);
      check("lose_last_hit1", msg_hit, 1);
      snap = msg1_cnt;
      shoot(40);
      check("lose_terminal", msg1_cnt, snap);
      check("no_timeout", timeout, 0);

`ifdef TURN_TIMEOUT_EN
      // unanswered shot runs the turn timer out
      async_reset();
      place_fleet();
      start_btn = 1'b1;
      tick();
      start_btn = 1'b0;
      tick(2);
      shoot(33);
      check("tmo_not_yet", timeout, 0);
      tick(25);
      check("tmo_flag", timeout, 1);
      check("tmo_ready1", ready1, 0);
      async_reset();
      check("tmo_cleared", timeout, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
